// File: rtl/varredura_display_pkg.sv
// Shared types, glyph constants and BCD-to-segment helper for the display scanner.
package display_pkg;

    localparam int unsigned N_DIG = 6;
    localparam int unsigned DIG_W = 5;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned IDX_W = 3;

    typedef logic [SEG_W-1:0] seg_t;

    // Glyphs, bit order {g,f,e,d,c,b,a}, active-low
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // One complete set of values shown in a frame
    typedef struct packed {
        logic [DIG_W-1:0] d5;
        logic [DIG_W-1:0] d4;
        logic [DIG_W-1:0] d3;
        logic [DIG_W-1:0] d2;
        logic [DIG_W-1:0] d1;
        logic [SEL_W-1:0] sel;
    } dados_t;

    // Decimal glyph for 0-9, E for anything else
    function automatic seg_t bcd_para_seg(input logic [DIG_W-1:0] v);
        seg_t s;
        case (v)
            5'd0:    s = SEG_0;
            5'd1:    s = SEG_1;
            5'd2:    s = SEG_2;
            5'd3:    s = SEG_3;
            5'd4:    s = SEG_4;
            5'd5:    s = SEG_5;
            5'd6:    s = SEG_6;
            5'd7:    s = SEG_7;
            5'd8:    s = SEG_8;
            5'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/varredura_display_if.sv
// Update strobe/digit bus into the scanner and the multiplexed display outputs.
interface varredura_display_if;
    import display_pkg::*;

    logic             atualizar;
    logic [DIG_W-1:0] dig_1;
    logic [DIG_W-1:0] dig_2;
    logic [DIG_W-1:0] dig_3;
    logic [DIG_W-1:0] dig_4;
    logic [DIG_W-1:0] dig_5;
    logic [SEL_W-1:0] seletor;
    seg_t             seg;
    logic [N_DIG-1:0] an;
    logic             dp;

    modport master (
        output atualizar, dig_1, dig_2, dig_3, dig_4, dig_5, seletor,
        input  seg, an, dp
    );

    modport slave (
        input  atualizar, dig_1, dig_2, dig_3, dig_4, dig_5, seletor,
        output seg, an, dp
    );

endinterface

// File: rtl/varredura_display_pre_escala.sv
// Free-running slot prescaler: counts 0..DIV-1, flags the wrap and the gap cycle.
module pre_escala #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c,
    output logic inicio_c
);

    localparam int unsigned PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Next count with wrap on the last cycle of the slot
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick_c   = (pre_q == PRE_MAX);
    assign inicio_c = (pre_q == '0);

endmodule

// File: rtl/varredura_display.sv
// Six-digit multiplexed seven-segment scanner with frame-synchronous update,
// leading-zero blanking and a one-cycle inter-digit blanking gap.
module varredura_display
    import display_pkg::*;
#(
    parameter int unsigned DIV = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    varredura_display_if.slave disp_if
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);

    logic             tick_c;
    logic             inicio_c;
    logic             fronteira_c;
    dados_t           entrada_c;

    logic [IDX_W-1:0] idx_q, idx_d;
    dados_t           hold_q, hold_d;
    dados_t           sh_q, sh_d;
    logic             pend_q, pend_d;
    seg_t             seg_q, seg_d;
    logic [N_DIG-1:0] an_q, an_d;
    logic             dp_q, dp_d;

    logic [N_DIG-1:0] zero_acima_c;
    logic [DIG_W-1:0] valor_c;
    logic             apagado_c;

    pre_escala #(
        .DIV (DIV)
    ) u_pre_escala (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_c   (tick_c),
        .inicio_c (inicio_c)
    );

    assign entrada_c = '{
        d5:  disp_if.dig_5,
        d4:  disp_if.dig_4,
        d3:  disp_if.dig_3,
        d2:  disp_if.dig_2,
        d1:  disp_if.dig_1,
        sel: disp_if.seletor
    };

    assign fronteira_c = tick_c && (idx_q == IDX_MAX);

    // Slot index advances once per prescaler wrap, wrapping after the last slot
    always_comb begin
        idx_d = idx_q;
        if (tick_c) begin
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Holding set, pending flag and shadow load; a frame only ever shows one data set
    always_comb begin
        hold_d = hold_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        if (disp_if.atualizar) begin
            hold_d = entrada_c;
            pend_d = 1'b1;
        end
        if (fronteira_c && (pend_q || disp_if.atualizar)) begin
            sh_d   = disp_if.atualizar ? entrada_c : hold_q;
            pend_d = 1'b0;
        end
    end

    // Zero run from the most significant digit down; a non-zero or E value breaks it
    always_comb begin
        zero_acima_c    = '0;
        zero_acima_c[5] = (sh_q.d5 == '0);
        zero_acima_c[4] = (sh_q.d4 == '0) && zero_acima_c[5];
        zero_acima_c[3] = (sh_q.d3 == '0) && zero_acima_c[4];
        zero_acima_c[2] = (sh_q.d2 == '0) && zero_acima_c[3];
    end

    // Value and blanking decision for the current slot
    always_comb begin
        valor_c   = '0;
        apagado_c = 1'b0;
        case (idx_q)
            3'd0: valor_c = DIG_W'(sh_q.sel);
            3'd1: valor_c = sh_q.d1;
            3'd2: begin
                valor_c   = sh_q.d2;
                apagado_c = zero_acima_c[2];
            end
            3'd3: begin
                valor_c   = sh_q.d3;
                apagado_c = zero_acima_c[3];
            end
            3'd4: begin
                valor_c   = sh_q.d4;
                apagado_c = zero_acima_c[4];
            end
            3'd5: begin
                valor_c   = sh_q.d5;
                apagado_c = zero_acima_c[5];
            end
            default: begin
                valor_c   = '0;
                apagado_c = 1'b1;
            end
        endcase
    end

    // Next display outputs; the first cycle of every slot is an all-dark gap
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        dp_d  = 1'b1;
        if (!inicio_c) begin
            an_d         = '1;
            an_d[idx_q]  = 1'b0;
            seg_d        = apagado_c ? SEG_BLANK : bcd_para_seg(valor_c);
            dp_d         = (idx_q != IDX_W'(1));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            hold_q <= '0;
            sh_q   <= '0;
            pend_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
            dp_q   <= 1'b1;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            dp_q   <= dp_d;
        end
    end

    assign disp_if.seg = seg_q;
    assign disp_if.an  = an_q;
    assign disp_if.dp  = dp_q;

endmodule

// File: tb/tb_varredura_display.sv
// Scoreboard bench for varredura_display: a cycle-count reference model pushes the
// expected display outputs each edge, a negedge monitor pops and compares.
module tb_varredura_display;

    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    typedef struct {
        logic [6:0] seg;
        logic [5:0] an;
        logic       dp;
    } saida_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    varredura_display_if vif ();

    varredura_display #(
        .DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_if (vif.slave)
    );

    logic [6:0] glifo [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int     erros  = 0;
    int     checks = 0;
    saida_t sb [$];

    // Model: index 0 = range code, 1..5 = digits
    int c;
    int mostra [6];
    int guarda [6];
    bit pend;

    function automatic saida_t esperado(input int ciclo, input int v [6]);
        saida_t s;
        int     slot;
        bit     apaga;
        s.seg = 7'h7F;
        s.an  = 6'h3F;
        s.dp  = 1'b1;
        if ((ciclo % DIV) != 0) begin
            slot  = (ciclo / DIV) % 6;
            apaga = (slot >= 2);
            for (int j = 2; j < 6; j++) begin
                if (j >= slot && v[j] != 0) apaga = 1'b0;
            end
            s.an[slot] = 1'b0;
            s.dp       = (slot == 1) ? 1'b0 : 1'b1;
            if (apaga)          s.seg = 7'h7F;
            else if (v[slot] > 9) s.seg = 7'h06;
            else                s.seg = glifo[v[slot]];
        end
        return s;
    endfunction

    // Reference model: expected output for the ending cycle, then absorb this edge's inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c    = 0;
            pend = 1'b0;
            for (int i = 0; i < 6; i++) begin
                mostra[i] = 0;
                guarda[i] = 0;
            end
            sb.delete();
        end else begin
            sb.push_back(esperado(c, mostra));
            if (vif.atualizar) begin
                guarda[0] = int'(vif.seletor);
                guarda[1] = int'(vif.dig_1);
                guarda[2] = int'(vif.dig_2);
                guarda[3] = int'(vif.dig_3);
                guarda[4] = int'(vif.dig_4);
                guarda[5] = int'(vif.dig_5);
                pend      = 1'b1;
            end
            if ((c % FRAME) == FRAME - 1 && pend) begin
                mostra = guarda;
                pend   = 1'b0;
            end
            c = c + 1;
        end
    end

    task automatic comparar(input string nome, input saida_t a, input saida_t e);
        checks++;
        if (a.seg !== e.seg || a.an !== e.an || a.dp !== e.dp) begin
            erros++;
            $display("FAIL %s t=%0t: got seg=%b an=%b dp=%b, want seg=%b an=%b dp=%b",
                     nome, $time, a.seg, a.an, a.dp, e.seg, e.an, e.dp);
        end
    endtask

    function automatic saida_t apagado();
        saida_t s;
        s.seg = 7'h7F;
        s.an  = 6'h3F;
        s.dp  = 1'b1;
        return s;
    endfunction

    function automatic saida_t atual();
        saida_t s;
        s.seg = vif.seg;
        s.an  = vif.an;
        s.dp  = vif.dp;
        return s;
    endfunction

    // Monitor: compare away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            comparar("reset_dark", atual(), apagado());
        end else if (sb.size() > 0) begin
            comparar("scan", atual(), sb.pop_front());
        end
    end

    task automatic lixo();
        vif.dig_1   = 5'($urandom);
        vif.dig_2   = 5'($urandom);
        vif.dig_3   = 5'($urandom);
        vif.dig_4   = 5'($urandom);
        vif.dig_5   = 5'($urandom);
        vif.seletor = 4'($urandom);
    endtask

    // Strobe during the current cycle (called at posedge+1)
    task automatic pulso(input logic [4:0] d5, input logic [4:0] d4, input logic [4:0] d3,
                         input logic [4:0] d2, input logic [4:0] d1, input logic [3:0] s);
        vif.dig_5     = d5;
        vif.dig_4     = d4;
        vif.dig_3     = d3;
        vif.dig_2     = d2;
        vif.dig_1     = d1;
        vif.seletor   = s;
        vif.atualizar = 1'b1;
        @(posedge clk);
        #1;
        vif.atualizar = 1'b0;
        lixo();
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until the current cycle has the given position within the frame
    task automatic ate(input int x);
        int n;
        n = 0;
        while ((c % FRAME) != x) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2 * FRAME) begin
                checks++;
                erros++;
                $display("FAIL wait_pos: got pos=%0d, want pos=%0d", c % FRAME, x);
                break;
            end
        end
    endtask

    function automatic logic [4:0] dig_aleat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 5'd0;
        if (r == 9) return 5'($urandom_range(10, 31));
        return 5'($urandom_range(1, 9));
    endfunction

    initial begin
        vif.atualizar = 1'b0;
        vif.dig_1     = '0;
        vif.dig_2     = '0;
        vif.dig_3     = '0;
        vif.dig_4     = '0;
        vif.dig_5     = '0;
        vif.seletor   = '0;

        // Reset and the blank first frame
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ciclos(FRAME + 3);

        // Load with leading zeros
        pulso(5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 4'd3);
        ciclos(2 * FRAME + 2);

        // Mid-frame strobe at slot 2
        ate(2 * DIV + 1);
        pulso(5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 4'd4);
        ciclos(2 * FRAME);

        // Strobe on the boundary cycle, then a second strobe in the same frame
        ate(FRAME - 1);
        pulso(5'd0, 5'd4, 5'd0, 5'd0, 5'd1, 4'd7);
        ate(DIV + 2);
        pulso(5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 4'd2);
        ciclos(2 * FRAME);

        // Invalid values
        pulso(5'd0, 5'd0, 5'd12, 5'd7, 5'd0, 4'd15);
        ciclos(2 * FRAME + 1);

        // Randomized updates, including back-to-back strobes
        for (int k = 0; k < 40; k++) begin
            ciclos($urandom_range(0, 2 * FRAME));
            pulso(dig_aleat(), dig_aleat(), dig_aleat(), dig_aleat(), dig_aleat(),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                pulso(dig_aleat(), dig_aleat(), dig_aleat(), dig_aleat(), dig_aleat(),
                      4'($urandom_range(0, 15)));
            end
        end
        ciclos(2 * FRAME);

        // Reset mid-frame with an update pending
        ate(0);
        ciclos(FRAME + 1);
        pulso(5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 4'd3);
        ate(3 * DIV + 1);
        #1;
        rst_n = 1'b0;
        #1;
        comparar("async_reset", atual(), apagado());
        ciclos(2);
        rst_n = 1'b1;
        ciclos(2 * FRAME + 2);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
